lsu_mem_stage: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle MEM stage.
- Sits between EX/MEM and WB and drives a req/ack data-memory bus.
- Handles byte-lane alignment, byte enables, sign/zero extension, misalignment traps and bus timeout.
- Stalls the pipeline while a bus access is outstanding.

---
 rtl/buceros_header.sv | 36 +++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu_mem_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buceros_header.sv
// Shared definitions for the load/store MEM stage.
//   - RISC-V funct3 access-size codes
//   - FSM state and access-size encodings
//   - XLEN-derived widths (byte-enable width, byte-offset width)
package buceros_header;

  localparam logic [2:0] INST_BYTE        = 3'b000;
  localparam logic [2:0] INST_HALF_WORD   = 3'b001;
  localparam logic [2:0] INST_WORD        = 3'b010;
  localparam logic [2:0] INST_DWORD       = 3'b011;
  localparam logic [2:0] INST_BYTE_U      = 3'b100;
  localparam logic [2:0] INST_HALF_WORD_U = 3'b101;
  localparam logic [2:0] INST_WORD_U      = 3'b110;

  typedef enum logic [0:0] {
    StIdle,
    StBus
  } lsu_state_e;

  // Encoded as log2 of the access size in bytes.
  typedef enum logic [1:0] {
    SizeB,
    SizeH,
    SizeW,
    SizeD
  } acc_size_e;

  function automatic int unsigned be_width(int unsigned xlen);
    return xlen / 8;
  endfunction

  function automatic int unsigned off_width(int unsigned xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the MEM stage (purely combinational).
//   Store side: st_size, st_offset, st_data -> st_be, st_wdata (data moved into addressed lanes)
//   Load side:  ld_size, ld_sign, ld_offset, ld_rdata -> ld_result (lane extracted, extended)
module lsu_align
  import buceros_header::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  acc_size_e                        st_size,
  input  logic [off_width(XLEN)-1:0]       st_offset,
  input  logic [XLEN-1:0]                  st_data,
  output logic [be_width(XLEN)-1:0]        st_be,
  output logic [XLEN-1:0]                  st_wdata,
  input  acc_size_e                        ld_size,
  input  logic                             ld_sign,
  input  logic [off_width(XLEN)-1:0]       ld_offset,
  input  logic [XLEN-1:0]                  ld_rdata,
  output logic [XLEN-1:0]                  ld_result
);

  localparam int unsigned BeW = be_width(XLEN);

  logic [BeW-1:0]  size_mask;
  logic [XLEN-1:0] shifted;

  always_comb begin
    size_mask = '0;
    unique case (st_size)
      SizeB:   size_mask = BeW'(1'b1);
      SizeH:   size_mask = BeW'(2'b11);
      SizeW:   size_mask = BeW'(4'hF);
      default: size_mask = '1;
    endcase
  end

  assign st_be    = size_mask << st_offset;
  assign st_wdata = st_data << {st_offset, 3'b000};

  assign shifted = ld_rdata >> {ld_offset, 3'b000};

  // Size casts of a $signed operand sign-extend; of an unsigned operand zero-extend.
  always_comb begin
    ld_result = shifted;
    unique case (ld_size)
      SizeB:   ld_result = ld_sign ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
      SizeH:   ld_result = ld_sign ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
      SizeW:   ld_result = ld_sign ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
      default: ld_result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Multi-cycle load/store MEM stage between EX/MEM and WB.
//   Upstream:  req_valid_i/req_ready_o handshake, wmem_en_i, rmem_en_i, mem_addr_i, funct3_i,
//              wreg_en_i, wreg_addr_i, wreg_data_i; stall_o freezes upstream.
//   Bus:       bus_req_o, bus_we_o, bus_addr_o (word aligned), bus_be_o, bus_wdata_o,
//              bus_ack_i, bus_rdata_i.
//   Writeback: wb_valid_o pulse with wreg_en_o, wreg_addr_o, wreg_data_o;
//              misalign_o and bus_err_o pulse alongside a trapped result.
// All outputs except req_ready_o/stall_o come straight from registers.
module lsu_mem_stage
  import buceros_header::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          wmem_en_i,
  input  logic                          rmem_en_i,
  input  logic [ADDR_WIDTH-1:0]         mem_addr_i,
  input  logic [2:0]                    funct3_i,
  input  logic                          wreg_en_i,
  input  logic [4:0]                    wreg_addr_i,
  input  logic [XLEN-1:0]               wreg_data_i,
  output logic                          bus_req_o,
  output logic                          bus_we_o,
  output logic [ADDR_WIDTH-1:0]         bus_addr_o,
  output logic [be_width(XLEN)-1:0]     bus_be_o,
  output logic [XLEN-1:0]               bus_wdata_o,
  input  logic                          bus_ack_i,
  input  logic [XLEN-1:0]               bus_rdata_i,
  output logic                          wb_valid_o,
  output logic                          wreg_en_o,
  output logic [4:0]                    wreg_addr_o,
  output logic [XLEN-1:0]               wreg_data_o,
  output logic                          stall_o,
  output logic                          misalign_o,
  output logic                          bus_err_o
);

  localparam int unsigned BeW   = be_width(XLEN);
  localparam int unsigned OffW  = off_width(XLEN);
  localparam int unsigned WaitW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  lsu_state_e            state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [BeW-1:0]        bus_be_q, bus_be_d;
  logic [XLEN-1:0]       bus_wdata_q, bus_wdata_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wreg_en_q, wreg_en_d;
  logic [4:0]            wreg_addr_q, wreg_addr_d;
  logic [XLEN-1:0]       wreg_data_q, wreg_data_d;
  logic                  misalign_q, misalign_d;
  logic                  bus_err_q, bus_err_d;
  // Load context kept for the duration of the bus access.
  acc_size_e             cap_size_q, cap_size_d;
  logic                  cap_sign_q, cap_sign_d;
  logic [OffW-1:0]       cap_off_q, cap_off_d;
  logic                  cap_wen_q, cap_wen_d;
  logic [4:0]            cap_waddr_q, cap_waddr_d;

  acc_size_e             size;
  logic                  sign;
  logic                  legal;
  logic                  misaligned;
  logic                  is_mem;
  logic [OffW-1:0]       offset;
  logic [BeW-1:0]        st_be;
  logic [XLEN-1:0]       st_wdata;
  logic [XLEN-1:0]       ld_result;

  assign is_mem = wmem_en_i | rmem_en_i;
  assign offset = mem_addr_i[OffW-1:0];

  // Access decode; unsigned codes are loads only, D/WU need a 64-bit datapath.
  always_comb begin
    size  = SizeB;
    sign  = 1'b1;
    legal = 1'b1;
    case (funct3_i)
      INST_BYTE:        size = SizeB;
      INST_HALF_WORD:   size = SizeH;
      INST_WORD:        size = SizeW;
      INST_DWORD: begin
        size  = SizeD;
        legal = (XLEN == 64);
      end
      INST_BYTE_U: begin
        sign  = 1'b0;
        legal = !wmem_en_i;
      end
      INST_HALF_WORD_U: begin
        size  = SizeH;
        sign  = 1'b0;
        legal = !wmem_en_i;
      end
      INST_WORD_U: begin
        size  = SizeW;
        sign  = 1'b0;
        legal = (XLEN == 64) && !wmem_en_i;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    unique case (size)
      SizeB:   misaligned = 1'b0;
      SizeH:   misaligned = mem_addr_i[0];
      SizeW:   misaligned = |mem_addr_i[1:0];
      default: misaligned = |mem_addr_i[2:0];
    endcase
  end

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .st_size   (size),
    .st_offset (offset),
    .st_data   (wreg_data_i),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_size   (cap_size_q),
    .ld_sign   (cap_sign_q),
    .ld_offset (cap_off_q),
    .ld_rdata  (bus_rdata_i),
    .ld_result (ld_result)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    wait_d      = wait_q;
    wb_valid_d  = 1'b0;
    wreg_en_d   = 1'b0;
    wreg_addr_d = '0;
    wreg_data_d = '0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    cap_size_d  = cap_size_q;
    cap_sign_d  = cap_sign_q;
    cap_off_d   = cap_off_q;
    cap_wen_d   = cap_wen_q;
    cap_waddr_d = cap_waddr_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (!is_mem) begin
            wb_valid_d  = 1'b1;
            wreg_en_d   = wreg_en_i;
            wreg_addr_d = wreg_addr_i;
            wreg_data_d = wreg_data_i;
          end else if (!legal || misaligned) begin
            wb_valid_d  = 1'b1;
            misalign_d  = 1'b1;
            wreg_addr_d = wreg_addr_i;
          end else begin
            state_d     = StBus;
            bus_req_d   = 1'b1;
            bus_we_d    = wmem_en_i;
            bus_addr_d  = {mem_addr_i[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
            bus_be_d    = st_be;
            bus_wdata_d = st_wdata;
            wait_d      = '0;
            cap_size_d  = size;
            cap_sign_d  = sign;
            cap_off_d   = offset;
            cap_wen_d   = wreg_en_i;
            cap_waddr_d = wreg_addr_i;
          end
        end
      end
      StBus: begin
        if (bus_ack_i || (wait_q == WaitLast)) begin
          // Ack wins over a coincident timeout.
          state_d     = StIdle;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
          wb_valid_d  = 1'b1;
          wreg_addr_d = cap_waddr_q;
          if (!bus_ack_i) begin
            bus_err_d = 1'b1;
          end else if (!bus_we_q) begin
            wreg_en_d   = cap_wen_q;
            wreg_data_d = ld_result;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      wait_q      <= '0;
      wb_valid_q  <= 1'b0;
      wreg_en_q   <= 1'b0;
      wreg_addr_q <= '0;
      wreg_data_q <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      cap_size_q  <= SizeB;
      cap_sign_q  <= 1'b0;
      cap_off_q   <= '0;
      cap_wen_q   <= 1'b0;
      cap_waddr_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      wait_q      <= wait_d;
      wb_valid_q  <= wb_valid_d;
      wreg_en_q   <= wreg_en_d;
      wreg_addr_q <= wreg_addr_d;
      wreg_data_q <= wreg_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      cap_size_q  <= cap_size_d;
      cap_sign_q  <= cap_sign_d;
      cap_off_q   <= cap_off_d;
      cap_wen_q   <= cap_wen_d;
      cap_waddr_q <= cap_waddr_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign stall_o     = req_valid_i && !req_ready_o;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wreg_en_o   = wreg_en_q;
  assign wreg_addr_o = wreg_addr_q;
  assign wreg_data_o = wreg_data_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a 32-bit instance (MAX_WAIT=4) checked through a writeback
// scoreboard plus per-cycle bus checks, and a 64-bit instance for doubleword/word lanes.
module tb_lsu_mem_stage;

  localparam int MaxWait = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, wmem_en, rmem_en, wreg_en;
  logic [31:0] mem_addr, wreg_data, bus_addr, bus_wdata, bus_rdata, wreg_data_o;
  logic [2:0]  funct3;
  logic [4:0]  wreg_addr, wreg_addr_o;
  logic        bus_req, bus_we, bus_ack, wb_valid, wreg_en_o, stall, misalign, bus_err;
  logic [3:0]  bus_be;

  logic        req_valid64, req_ready64, bus_req64, bus_we64, bus_ack64, wb_valid64;
  logic        wreg_en_o64, stall64, misalign64, bus_err64;
  logic [2:0]  funct3_64;
  logic [31:0] mem_addr64, bus_addr64;
  logic [63:0] bus_wdata64, bus_rdata64, wreg_data_o64;
  logic [7:0]  bus_be64;
  logic [4:0]  wreg_addr_o64;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(32), .ADDR_WIDTH(32), .MAX_WAIT(MaxWait)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .wmem_en_i(wmem_en), .rmem_en_i(rmem_en), .mem_addr_i(mem_addr), .funct3_i(funct3),
    .wreg_en_i(wreg_en), .wreg_addr_i(wreg_addr), .wreg_data_i(wreg_data),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
    .wb_valid_o(wb_valid), .wreg_en_o(wreg_en_o), .wreg_addr_o(wreg_addr_o),
    .wreg_data_o(wreg_data_o), .stall_o(stall), .misalign_o(misalign), .bus_err_o(bus_err)
  );

  lsu_mem_stage #(.XLEN(64), .ADDR_WIDTH(32), .MAX_WAIT(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid64), .req_ready_o(req_ready64),
    .wmem_en_i(1'b0), .rmem_en_i(1'b1), .mem_addr_i(mem_addr64), .funct3_i(funct3_64),
    .wreg_en_i(1'b1), .wreg_addr_i(5'd9), .wreg_data_i(64'd0),
    .bus_req_o(bus_req64), .bus_we_o(bus_we64), .bus_addr_o(bus_addr64), .bus_be_o(bus_be64),
    .bus_wdata_o(bus_wdata64), .bus_ack_i(bus_ack64), .bus_rdata_i(bus_rdata64),
    .wb_valid_o(wb_valid64), .wreg_en_o(wreg_en_o64), .wreg_addr_o(wreg_addr_o64),
    .wreg_data_o(wreg_data_o64), .stall_o(stall64), .misalign_o(misalign64),
    .bus_err_o(bus_err64)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    bit        wen;
    bit [4:0]  waddr;
    bit [31:0] wdata;
    bit        mis;
    bit        err;
    bit        chk_addr;
    bit        chk_data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Monitor: every writeback pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wb_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_wb", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("wb_wreg_en", wreg_en_o, mon_e.wen);
          check("wb_misalign", misalign, mon_e.mis);
          check("wb_bus_err", bus_err, mon_e.err);
          if (mon_e.chk_addr) check("wb_wreg_addr", wreg_addr_o, mon_e.waddr);
          if (mon_e.chk_data) check("wb_wreg_data", wreg_data_o, mon_e.wdata);
        end
      end else begin
        check("pulse_without_wb", {misalign, bus_err}, 2'b00);
      end
    end
  end

  // Issue one operation on the 32-bit instance and play the bus side.
  // delay: ack on BUS cycle delay+1; delay >= MaxWait means no ack (timeout).
  task automatic do_op(input bit we, input bit re, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] data, input bit wen, input bit [4:0] waddr,
                       input int delay, input bit [31:0] rdata_v, input bit stray);
    int        nb;
    bit        sgn, legal, mem, access;
    int        off;
    bit [63:0] mask, v;
    bit [3:0]  exp_be;
    bit [31:0] lanes, exp_wd;
    exp_t      e_res, e_err;

    nb = 0; sgn = 1;
    case (f3)
      3'd0: nb = 1;
      3'd1: nb = 2;
      3'd2: nb = 4;
      3'd4: begin nb = 1; sgn = 0; end
      3'd5: begin nb = 2; sgn = 0; end
      default: nb = 0;
    endcase
    legal  = (nb != 0) && !(we && !sgn);
    mem    = we || re;
    off    = int'(addr % 4);
    access = mem && legal && ((addr % nb) == 0);
    exp_be = 4'((1 << nb) - 1) << off;
    lanes  = '0;
    for (int i = 0; i < 4; i++) if (exp_be[i]) lanes[8*i +: 8] = 8'hFF;
    exp_wd = (data << (8 * off)) & lanes;

    e_res = '{wen: 0, waddr: waddr, wdata: 0, mis: 0, err: 0, chk_addr: 0, chk_data: 0};
    e_err = '{wen: 0, waddr: waddr, wdata: 0, mis: 0, err: 1, chk_addr: 0, chk_data: 0};
    if (!mem) begin
      e_res = '{wen: wen, waddr: waddr, wdata: data, mis: 0, err: 0, chk_addr: 1, chk_data: 1};
    end else if (!access) begin
      e_res.mis = 1;
    end else if (we) begin
      e_res.chk_data = 1;
    end else begin
      mask = (64'd1 << (8 * nb)) - 1;
      v    = (64'(rdata_v) >> (8 * off)) & mask;
      if (sgn && v[8*nb-1]) v = v | ~mask;
      e_res = '{wen: wen, waddr: waddr, wdata: v[31:0], mis: 0, err: 0, chk_addr: 1,
                chk_data: 1};
    end

    check("ready_before_issue", req_ready, 1);
    req_valid = 1; wmem_en = we; rmem_en = re; funct3 = f3; mem_addr = addr;
    wreg_data = data; wreg_en = wen; wreg_addr = waddr; bus_ack = stray;
    if (!access) sb_q.push_back(e_res);
    @(negedge clk);
    bus_ack = 0;
    if (access) begin
      for (int cyc = 1; cyc <= MaxWait; cyc++) begin
        check("bus_req_held", bus_req, 1);
        check("ready_low_in_bus", req_ready, 0);
        check("stall_in_bus", stall, 1);
        check("bus_addr", bus_addr, addr & ~32'h3);
        check("bus_be", bus_be, exp_be);
        check("bus_we", bus_we, we);
        if (we) check("bus_wdata_lanes", bus_wdata & lanes, exp_wd);
        if (cyc == delay + 1) begin
          bus_ack = 1; bus_rdata = rdata_v;
          sb_q.push_back(e_res);
          @(negedge clk);
          bus_ack = 0; bus_rdata = $urandom;
          break;
        end
        bus_rdata = $urandom;
        if (cyc == MaxWait) sb_q.push_back(e_err);
        @(negedge clk);
      end
    end
    check("bus_req_done", bus_req, 0);
    check("ready_after_op", req_ready, 1);
    check("stall_after_op", stall, 0);
    req_valid = 0;
  endtask

  task automatic ld64(input bit [2:0] f3, input bit [31:0] addr, input bit [63:0] rdata_v,
                      input bit [7:0] exp_be, input bit [63:0] exp_data);
    req_valid64 = 1; funct3_64 = f3; mem_addr64 = addr;
    @(negedge clk);
    req_valid64 = 0;
    check("x64_bus_req", bus_req64, 1);
    check("x64_bus_be", bus_be64, exp_be);
    check("x64_bus_addr", bus_addr64, addr & ~32'h7);
    bus_ack64 = 1; bus_rdata64 = rdata_v;
    @(negedge clk);
    bus_ack64 = 0;
    check("x64_wb_valid", wb_valid64, 1);
    check("x64_wreg_en", wreg_en_o64, 1);
    check("x64_wreg_data", wreg_data_o64, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [2:0]  f3;
    bit [31:0] a;
    int        kind;

    rst_n = 0; req_valid = 0; wmem_en = 0; rmem_en = 0; funct3 = 0; mem_addr = 0;
    wreg_en = 0; wreg_addr = 0; wreg_data = 0; bus_ack = 0; bus_rdata = 0;
    req_valid64 = 0; funct3_64 = 0; mem_addr64 = 0; bus_ack64 = 0; bus_rdata64 = 0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", bus_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_bus_be", bus_be, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_ready", req_ready, 1);

    // Directed cases.
    do_op(1, 0, 3'b000, 32'h1003, 32'h000000A5, 1, 5'd3, 1, 32'h0, 0);   // SB
    do_op(0, 1, 3'b001, 32'h2002, 32'h0, 1, 5'd4, 2, 32'h8001_0000, 0);  // LH
    do_op(0, 1, 3'b101, 32'h2002, 32'h0, 1, 5'd5, 2, 32'h8001_0000, 0);  // LHU
    do_op(0, 1, 3'b010, 32'h3001, 32'h0, 1, 5'd6, 0, 32'h0, 0);          // LW misaligned
    do_op(0, 1, 3'b010, 32'h3004, 32'h0, 1, 5'd7, 99, 32'h0, 0);         // timeout
    do_op(0, 1, 3'b010, 32'h3008, 32'h0, 1, 5'd8, MaxWait - 1, 32'hCAFE_F00D, 0); // ack at limit
    do_op(0, 0, 3'b000, 32'h0, 32'h1234, 1, 5'd10, 0, 32'h0, 0);         // non-memory
    do_op(0, 1, 3'b000, 32'h4001, 32'h0, 1, 5'd11, 0, 32'h0000_8000, 1); // LB, stray idle ack
    do_op(1, 0, 3'b100, 32'h5000, 32'h55, 0, 5'd12, 0, 32'h0, 0);        // SBU illegal
    do_op(0, 1, 3'b011, 32'h5000, 32'h0, 1, 5'd13, 0, 32'h0, 0);         // LD illegal at XLEN=32

    // Randomized operations.
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom % 8);
      f3   = 3'($urandom);
      a    = $urandom & 32'h0000_FFFF;
      if ($urandom % 4 != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
      do_op(kind >= 5, (kind >= 2 && kind <= 4) || kind == 7, f3, a, $urandom,
            1'($urandom), 5'($urandom), int'($urandom % 6), $urandom, ($urandom % 4) == 0);
    end

    // Reset in the middle of a bus access; the late ack must be ignored.
    req_valid = 1; wmem_en = 0; rmem_en = 1; funct3 = 3'b001; mem_addr = 32'h2002;
    @(negedge clk);
    check("pre_reset_bus_req", bus_req, 1);
    rst_n = 0;
    #1;
    check("midrst_bus_req", bus_req, 0);
    check("midrst_bus_we", bus_we, 0);
    check("midrst_bus_be", bus_be, 0);
    check("midrst_bus_addr", bus_addr, 0);
    check("midrst_bus_wdata", bus_wdata, 0);
    check("midrst_wb", {wb_valid, wreg_en_o, misalign, bus_err}, 0);
    check("midrst_wreg", {wreg_addr_o, wreg_data_o}, 0);
    req_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    bus_ack = 1;
    @(negedge clk);
    bus_ack = 0;
    check("stale_ack_no_wb", wb_valid, 0);
    @(negedge clk);
    check("stale_ack_no_wb2", wb_valid, 0);

    // 64-bit datapath.
    ld64(3'b011, 32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
    ld64(3'b010, 32'hC, 64'h8000_0000_1234_5678, 8'hF0, 64'hFFFF_FFFF_8000_0000);
    ld64(3'b110, 32'hC, 64'h8000_0000_1234_5678, 8'hF0, 64'h0000_0000_8000_0000);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
